// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar command receiver: FSM state codes (also shown on
// the debug display) and the ASCII command set with its decoder.
package sonar_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    START       = 4'd1,
    DADOS       = 4'd2,
    PARIDADE    = 4'd3,
    STOP        = 4'd4,
    ENTREGA     = 4'd5,
    ESPERA_ALTO = 4'd6
  } estado_t;

  localparam logic [7:0] CMD_LIGAR_U     = 8'h4C;
  localparam logic [7:0] CMD_LIGAR_L     = 8'h6C;
  localparam logic [7:0] CMD_DESLIGAR_U  = 8'h44;
  localparam logic [7:0] CMD_DESLIGAR_L  = 8'h64;
  localparam logic [7:0] CMD_REINICIA_U  = 8'h52;
  localparam logic [7:0] CMD_REINICIA_L  = 8'h72;

  typedef enum logic [1:0] {
    CMD_NENHUM,
    CMD_LIGA,
    CMD_DESLIGA,
    CMD_REINICIA
  } cmd_t;

  function automatic cmd_t decodifica(input logic [7:0] b);
    case (b)
      CMD_LIGAR_U,    CMD_LIGAR_L:    return CMD_LIGA;
      CMD_DESLIGAR_U, CMD_DESLIGAR_L: return CMD_DESLIGA;
      CMD_REINICIA_U, CMD_REINICIA_L: return CMD_REINICIA;
      default:                        return CMD_NENHUM;
    endcase
  endfunction

endpackage

// File: rtl/sonar_rx_comandos_contador_baud.sv
// Bit-timing counter: counts 0..M-1 while enabled, wraps, and flags the half-bit
// (meio) and full-bit (fim) points. Clear has priority over enable.
module contador_baud #(
  parameter int unsigned M = 434
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic limpa_i,
  input  logic conta_i,
  output logic fim_o,
  output logic meio_o
);

  localparam int unsigned W = (M > 2) ? $clog2(M) : 1;

  logic [W-1:0] cont_q, cont_d;

  always_comb begin
    cont_d = cont_q;
    if (limpa_i)
      cont_d = '0;
    else if (conta_i)
      cont_d = fim_o ? '0 : cont_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cont_q <= '0;
    else          cont_q <= cont_d;
  end

  assign fim_o  = (cont_q == W'(M - 1));
  assign meio_o = (cont_q == W'(M / 2 - 1));

endmodule

// File: rtl/sonar_rx_comandos.sv
// UART receiver for the sonar command channel with ASCII command decode.
// Default frame is 8N1; defining RX_PARIDADE_EN selects 8E1 and adds erro_paridade.
module sonar_rx_comandos
  import sonar_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [7:0] dado,
  output logic       pronto,
  output logic       erro_framing,
  output logic       ligar,
  output logic       reinicia,
  output logic       cmd_invalido,
`ifdef RX_PARIDADE_EN
  output logic       erro_paridade,
`endif
  output logic [3:0] db_estado
);

  localparam int unsigned CICLOS_BIT = CLK_FREQ / BAUD;

  logic [1:0] sinc_q;
  logic       rx;
  estado_t    estado_q, estado_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       fim, meio, limpa, conta;

  logic [7:0] dado_q, dado_d;
  logic       pronto_q, pronto_d;
  logic       erro_framing_q, erro_framing_d;
  logic       ligar_q, ligar_d;
  logic       reinicia_q, reinicia_d;
  logic       cmd_invalido_q, cmd_invalido_d;
`ifdef RX_PARIDADE_EN
  logic       paridade_q, paridade_d;
  logic       erro_paridade_q, erro_paridade_d;
`endif

  assign rx = sinc_q[1];

  // Counter restarts on every state change, so each state times from its own entry.
  assign limpa = (estado_d != estado_q);
  assign conta = (estado_q == START) || (estado_q == DADOS) ||
                 (estado_q == PARIDADE) || (estado_q == STOP);

  contador_baud #(.M(CICLOS_BIT)) u_contador (
    .clk_i   (clock),
    .rst_n_i (reset),
    .limpa_i (limpa),
    .conta_i (conta),
    .fim_o   (fim),
    .meio_o  (meio)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc_q         <= '1;
      estado_q       <= INICIAL;
      shift_q        <= '0;
      idx_q          <= '0;
      dado_q         <= '0;
      pronto_q       <= 1'b0;
      erro_framing_q <= 1'b0;
      ligar_q        <= 1'b0;
      reinicia_q     <= 1'b0;
      cmd_invalido_q <= 1'b0;
`ifdef RX_PARIDADE_EN
      paridade_q      <= 1'b0;
      erro_paridade_q <= 1'b0;
`endif
    end else begin
      sinc_q         <= {sinc_q[0], entrada_serial};
      estado_q       <= estado_d;
      shift_q        <= shift_d;
      idx_q          <= idx_d;
      dado_q         <= dado_d;
      pronto_q       <= pronto_d;
      erro_framing_q <= erro_framing_d;
      ligar_q        <= ligar_d;
      reinicia_q     <= reinicia_d;
      cmd_invalido_q <= cmd_invalido_d;
`ifdef RX_PARIDADE_EN
      paridade_q      <= paridade_d;
      erro_paridade_q <= erro_paridade_d;
`endif
    end
  end

  always_comb begin
    estado_d = estado_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
`ifdef RX_PARIDADE_EN
    paridade_d = paridade_q;
`endif
    case (estado_q)
      INICIAL: begin
        idx_d = '0;
        if (!rx) estado_d = START;
      end
      START: begin
        if (meio) estado_d = rx ? INICIAL : DADOS;
      end
      DADOS: begin
        if (fim) begin
          shift_d = {rx, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef RX_PARIDADE_EN
            estado_d = PARIDADE;
`else
            estado_d = STOP;
`endif
          end
        end
      end
`ifdef RX_PARIDADE_EN
      PARIDADE: begin
        if (fim) begin
          paridade_d = rx;
          estado_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (fim) estado_d = rx ? ENTREGA : ESPERA_ALTO;
      end
      ENTREGA:     estado_d = INICIAL;
      ESPERA_ALTO: if (rx) estado_d = INICIAL;
      default:     estado_d = INICIAL;
    endcase
  end

  always_comb begin
    logic aceito;
    dado_d         = dado_q;
    ligar_d        = ligar_q;
    pronto_d       = 1'b0;
    erro_framing_d = 1'b0;
    reinicia_d     = 1'b0;
    cmd_invalido_d = 1'b0;
    aceito         = 1'b1;
`ifdef RX_PARIDADE_EN
    erro_paridade_d = 1'b0;
    aceito          = ~^{shift_q, paridade_q};
`endif
    if ((estado_q == STOP) && fim && !rx)
      erro_framing_d = 1'b1;
    if (estado_q == ENTREGA) begin
`ifdef RX_PARIDADE_EN
      erro_paridade_d = ~aceito;
`endif
      if (aceito) begin
        dado_d   = shift_q;
        pronto_d = 1'b1;
        case (decodifica(shift_q))
          CMD_LIGA:     ligar_d        = 1'b1;
          CMD_DESLIGA:  ligar_d        = 1'b0;
          CMD_REINICIA: reinicia_d     = 1'b1;
          default:      cmd_invalido_d = 1'b1;
        endcase
      end
    end
  end

  assign dado         = dado_q;
  assign pronto       = pronto_q;
  assign erro_framing = erro_framing_q;
  assign ligar        = ligar_q;
  assign reinicia     = reinicia_q;
  assign cmd_invalido = cmd_invalido_q;
`ifdef RX_PARIDADE_EN
  assign erro_paridade = erro_paridade_q;
`endif
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_sonar_rx_comandos.sv
// Self-checking bench for sonar_rx_comandos: UART frames driven from a bit-time model,
// outputs counted by a pulse monitor and compared against a command-level model.
`timescale 1ns/1ps
module tb_sonar_rx_comandos;

  localparam int CLK_NS = 20;
  localparam int BIT_NS = (50_000_000 / 115200) * CLK_NS;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       entrada_serial = 1'b1;
  logic [7:0] dado;
  logic       pronto, erro_framing, ligar, reinicia, cmd_invalido;
  logic [3:0] db_estado;
`ifdef RX_PARIDADE_EN
  logic       erro_paridade;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  int c_pronto = 0, c_ferr = 0, c_rein = 0, c_inv = 0, c_perr = 0;
  logic [7:0] got_q[$];

  always #(CLK_NS/2) clock = ~clock;

  sonar_rx_comandos #(.CLK_FREQ(50_000_000), .BAUD(115200)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .dado           (dado),
    .pronto         (pronto),
    .erro_framing   (erro_framing),
    .ligar          (ligar),
    .reinicia       (reinicia),
    .cmd_invalido   (cmd_invalido),
`ifdef RX_PARIDADE_EN
    .erro_paridade  (erro_paridade),
`endif
    .db_estado      (db_estado)
  );

  // Every cycle a pulse is high counts once, so a stretched pulse shows up as an extra count.
  always @(negedge clock) begin
    if (pronto) begin
      c_pronto++;
      got_q.push_back(dado);
    end
    if (erro_framing) c_ferr++;
    if (reinicia)     c_rein++;
    if (cmd_invalido) c_inv++;
`ifdef RX_PARIDADE_EN
    if (erro_paridade) c_perr++;
`endif
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bad);
    entrada_serial = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      entrada_serial = b[i];
      #(BIT_NS);
    end
`ifdef RX_PARIDADE_EN
    entrada_serial = (^b) ^ par_bad;
    #(BIT_NS);
`else
    if (par_bad) entrada_serial = 1'b1;
`endif
    entrada_serial = stop_bit;
    #(BIT_NS);
    entrada_serial = 1'b1;
  endtask

  task automatic idle(input int ciclos);
    #(ciclos * CLK_NS);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    entrada_serial = 1'b1;
    idle(5);
    #3;
    n_checks++; if ({dado, pronto, erro_framing, ligar, reinicia, cmd_invalido} !== 13'd0)
      $display("FAIL reset_outputs got %h want 0", {dado, pronto, erro_framing, ligar, reinicia, cmd_invalido}); else n_pass++;
    n_checks++; if (db_estado !== 4'd0) $display("FAIL reset_estado got %0d want 0", db_estado); else n_pass++;
    reset = 1'b1;
    idle(10);
  endtask

  task automatic test_ligar;
    int p0 = c_pronto, i0 = c_inv;
    send_frame(8'h4C, 1'b1, 1'b0);
    idle(20);
    n_checks++; if (c_pronto - p0 !== 1) $display("FAIL ligar_pronto got %0d want 1", c_pronto - p0); else n_pass++;
    n_checks++; if (dado !== 8'h4C) $display("FAIL ligar_dado got %h want 4c", dado); else n_pass++;
    n_checks++; if (ligar !== 1'b1) $display("FAIL ligar_level got %b want 1", ligar); else n_pass++;
    n_checks++; if (c_inv - i0 !== 0) $display("FAIL ligar_invalido got %0d want 0", c_inv - i0); else n_pass++;
    n_checks++; if (db_estado !== 4'd0) $display("FAIL ligar_estado got %0d want 0", db_estado); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int p0 = c_pronto;
    send_frame(8'h4C, 1'b1, 1'b0);
    send_frame(8'h64, 1'b1, 1'b0);
    idle(20);
    n_checks++; if (c_pronto - p0 !== 2) $display("FAIL b2b_pronto got %0d want 2", c_pronto - p0); else n_pass++;
    n_checks++; if (ligar !== 1'b0) $display("FAIL b2b_ligar got %b want 0", ligar); else n_pass++;
    n_checks++; if (dado !== 8'h64) $display("FAIL b2b_dado got %h want 64", dado); else n_pass++;
  endtask

  task automatic test_glitch;
    int p0 = c_pronto, f0 = c_ferr;
    entrada_serial = 1'b0;
    idle(100);
    entrada_serial = 1'b1;
    idle(400);
    n_checks++; if (c_pronto - p0 !== 0) $display("FAIL glitch_pronto got %0d want 0", c_pronto - p0); else n_pass++;
    n_checks++; if (c_ferr - f0 !== 0) $display("FAIL glitch_framing got %0d want 0", c_ferr - f0); else n_pass++;
    n_checks++; if (db_estado !== 4'd0) $display("FAIL glitch_estado got %0d want 0", db_estado); else n_pass++;
  endtask

  task automatic test_framing;
    int p0 = c_pronto, f0 = c_ferr, r0 = c_rein;
    logic [7:0] dado_antes = dado;
    logic       ligar_antes = ligar;
    send_frame(8'h41, 1'b0, 1'b0);
    idle(20);
    n_checks++; if (c_ferr - f0 !== 1) $display("FAIL framing_pulse got %0d want 1", c_ferr - f0); else n_pass++;
    n_checks++; if (c_pronto - p0 !== 0) $display("FAIL framing_pronto got %0d want 0", c_pronto - p0); else n_pass++;
    n_checks++; if (dado !== dado_antes) $display("FAIL framing_dado got %h want %h", dado, dado_antes); else n_pass++;
    n_checks++; if (ligar !== ligar_antes) $display("FAIL framing_ligar got %b want %b", ligar, ligar_antes); else n_pass++;
    send_frame(8'h52, 1'b1, 1'b0);
    idle(20);
    n_checks++; if (c_rein - r0 !== 1) $display("FAIL framing_reinicia got %0d want 1", c_rein - r0); else n_pass++;
    n_checks++; if (dado !== 8'h52) $display("FAIL framing_dado_r got %h want 52", dado); else n_pass++;
  endtask

`ifdef RX_PARIDADE_EN
  task automatic test_paridade;
    int p0 = c_pronto, e0 = c_perr;
    send_frame(8'h4C, 1'b1, 1'b1);
    idle(20);
    n_checks++; if (c_perr - e0 !== 1) $display("FAIL paridade_pulse got %0d want 1", c_perr - e0); else n_pass++;
    n_checks++; if (c_pronto - p0 !== 0) $display("FAIL paridade_pronto got %0d want 0", c_pronto - p0); else n_pass++;
    n_checks++; if (ligar !== 1'b0) $display("FAIL paridade_ligar got %b want 0", ligar); else n_pass++;
  endtask
`endif

  task automatic test_reset_mid;
    logic [7:0] b = 8'h4C;
    send_frame(8'h4C, 1'b1, 1'b0);
    idle(20);
    entrada_serial = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      entrada_serial = b[i];
      #(BIT_NS);
    end
    reset = 1'b0;
    entrada_serial = 1'b1;
    idle(5);
    n_checks++; if ({dado, pronto, erro_framing, ligar, reinicia, cmd_invalido} !== 13'd0)
      $display("FAIL midreset_outputs got %h want 0", {dado, pronto, erro_framing, ligar, reinicia, cmd_invalido}); else n_pass++;
    n_checks++; if (db_estado !== 4'd0) $display("FAIL midreset_estado got %0d want 0", db_estado); else n_pass++;
    reset = 1'b1;
    idle(50);
    send_frame(8'h4C, 1'b1, 1'b0);
    idle(20);
    n_checks++; if (ligar !== 1'b1) $display("FAIL midreset_ligar got %b want 1", ligar); else n_pass++;
    n_checks++; if (dado !== 8'h4C) $display("FAIL midreset_dado got %h want 4c", dado); else n_pass++;
  endtask

  task automatic test_random;
    logic [7:0] cmds[6] = '{8'h4C, 8'h6C, 8'h44, 8'h64, 8'h52, 8'h72};
    logic [7:0] enviados[$];
    logic       exp_ligar = ligar;
    int         exp_rein = 0, exp_inv = 0;
    int         r0 = c_rein, i0 = c_inv, f0 = c_ferr;
    logic [7:0] b;
    got_q.delete();
    for (int n = 0; n < 8; n++) begin
      b = ($urandom_range(1, 0) == 1) ? cmds[$urandom_range(5, 0)] : 8'($urandom);
      enviados.push_back(b);
      if (b == "L" || b == "l")      exp_ligar = 1'b1;
      else if (b == "D" || b == "d") exp_ligar = 1'b0;
      else if (b == "R" || b == "r") exp_rein++;
      else                           exp_inv++;
      send_frame(b, 1'b1, 1'b0);
    end
    idle(20);
    n_checks++; if (got_q.size() !== 8) $display("FAIL rand_count got %0d want 8", got_q.size()); else n_pass++;
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (n >= got_q.size()) $display("FAIL rand_byte%0d got none want %h", n, enviados[n]);
      else if (got_q[n] !== enviados[n]) $display("FAIL rand_byte%0d got %h want %h", n, got_q[n], enviados[n]);
      else n_pass++;
    end
    n_checks++; if (ligar !== exp_ligar) $display("FAIL rand_ligar got %b want %b", ligar, exp_ligar); else n_pass++;
    n_checks++; if (c_rein - r0 !== exp_rein) $display("FAIL rand_reinicia got %0d want %0d", c_rein - r0, exp_rein); else n_pass++;
    n_checks++; if (c_inv - i0 !== exp_inv) $display("FAIL rand_invalido got %0d want %0d", c_inv - i0, exp_inv); else n_pass++;
    n_checks++; if (c_ferr - f0 !== 0) $display("FAIL rand_framing got %0d want 0", c_ferr - f0); else n_pass++;
  endtask

  initial begin
    #3;
    test_reset;
    test_ligar;
    test_back_to_back;
`ifdef RX_PARIDADE_EN
    test_paridade;
`endif
    test_glitch;
    test_framing;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
